acc_core_seq: RTL and testbench
===============================

Name: acc_core_seq

Overview:
- Parametrised successor of the 8-bit accumulator processor top level: one 9-bit instruction per clock, R0 as accumulator, relative branches, data load/store.
- Generalised in data width, register count and PC width.
- Adds a req/done run handshake FSM, a HALT opcode, registered carry and zero flags, an instruction counter and a watchdog timeout.
- Instruction ROM and data memory stay external; this block is the core.

Parameters:
- DW, 8, data/register width (DW >= 8).
- NREG, 16, register count including accumulator R0; power of 2, at most 16.
- PC_WIDTH, 12, program counter width.
- CW, 16, instruction counter width.
- MAX_CYCLES, 0, watchdog limit in executed instructions; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  start request, level.
- done  out  1  run finished, held high in DONE.
- timeout  out  1  run ended by the watchdog; valid while done=1.
- imem_addr  out  PC_WIDTH  current PC.
- imem_data  in  9  machine code at imem_addr, combinational.
- dmem_addr  out  DW  R[instr[3:0]].
- dmem_wdata  out  DW  accumulator value.
- dmem_we  out  1  store strobe.
- dmem_rdata  in  DW  combinational read data at dmem_addr.
- instr_count  out  CW  instructions executed in the current or last run.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; PC, all registers, carry C and zero Z are 0.
  - done=0, timeout=0, dmem_we=0, instr_count=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: req=1 -> RUN next cycle with PC=0, instr_count=0, timeout=0.
  - RUN: executes imem_data each cycle and increments instr_count (saturating).
  - RUN -> DONE on a HALT opcode or when the watchdog fires.
  - DONE: done=1; req=0 -> IDLE; req held high keeps DONE (no auto-restart).
- Register and flag values persist across runs; only reset clears them.
- req falling mid-run is ignored.
- Instruction decode:
  - instr[8]=1: LDI, acc <= zero-extended instr[7:0].
  - Otherwise op=instr[7:4], r=instr[3:0], with r taken modulo NREG.
- Opcodes:
  - 0 HALT.
  - 1 MOV, R[r] <= acc.
  - 2 LDR, acc <= R[r].
  - 3 ADD, {C,acc} <= acc+R[r].
  - 4 ADC, {C,acc} <= acc+R[r]+C.
  - 5 SUB, acc <= acc-R[r]; C=1 iff acc >= R[r] (unsigned).
  - 6 AND, 7 OR, 8 XOR: acc <= acc op R[r]; C unchanged.
  - 9 SHL: {C,acc} <= {acc,C}.
  - A SHR: {acc,C} <= {C,acc}.
  - B LD, acc <= dmem_rdata.
  - C ST: dmem_we=1 this cycle, combinational in RUN only.
  - D BNZ: if Z=0, PC <= PC + sext(R[r]); otherwise PC+1.
  - E JMP, PC <= PC + sext(R[r]).
  - F CLC, C <= 0.
- Non-branch instructions advance PC by 1; PC wraps modulo 2^PC_WIDTH.
- Branch offset: R[r] sign-extended or truncated to PC_WIDTH.
- Z is updated on every accumulator write (acc result == 0); otherwise held.
- MOV with r=0 is a NOP.
- Latency:
  - Single-cycle execute; results are visible to the next instruction.
  - done rises the cycle after HALT executes.
  - Completion is 1 cycle after the last instruction.
- Watchdog: when MAX_CYCLES != 0 and instr_count reaches MAX_CYCLES at the end of a cycle, -> DONE with timeout=1.
  - A HALT in that same cycle wins: timeout=0.
- Outside RUN: PC and registers are frozen and dmem_we=0.
- imem_addr is driven by PC in all states.

Decomposition:
- Package acc_core_pkg holds:
  - opcode enum (op_t, 4 bits), state enum (IDLE/RUN/DONE);
  - INSTR_W=9 and IMM_W=8 constants;
  - ALU result struct {result, carry}.
- Sub-module acc_alu:
  - combinational, parametrised by DW;
  - takes op, acc, operand and carry-in;
  - returns result, carry-out and a write-acc flag.
- FSM, PC, register file and flags live in acc_core_seq.

Test Plan:
- Reset mid-run: drop reset while in RUN -> done=0, imem_addr=0, instr_count=0 asynchronously; the next req starts cleanly at PC=0.
- Arithmetic: program LDI 0xF0; MOV R1; LDI 0x20; ADD R1; HALT -> acc=0x10, C=1, Z=0, done=1 one cycle after HALT, instr_count=5.
- Branch loop: LDI 3; MOV R1; LDI 1; MOV R2; LDI 0xFD (-3); MOV R3; LDR R1; SUB R2; MOV R1; BNZ R3; HALT.
  - Required: the loop body runs 3 times; final R1=0, Z=1; HALT at PC 10 reached.
- Memory: LDI 0x05; MOV R4; LDI 0xA5; ST R4; LDI 0; LD R4; HALT.
  - Required: dmem_we high exactly one cycle with addr 0x05, data 0xA5; final acc=0xA5.
- Watchdog: MAX_CYCLES=4 with program JMP R0 at PC 0 (infinite loop, R0=0) -> done=1, timeout=1, instr_count=4.
  - Holding req high keeps DONE; req=0 -> IDLE.
- Width/wrap: DW=16, PC_WIDTH=4; program reaches PC=15 with a non-branch -> PC wraps to 0.
  - LDI 0xFF yields acc=0x00FF; SHL with C=1 yields 0x01FF, C=0.

Source files
------------

// File: rtl/acc_core_pkg.sv
// acc_core_pkg: shared types for the accumulator core
// opcodes, run states and the ALU result bundle
package acc_core_pkg;

  localparam int INSTR_W = 9;
  localparam int IMM_W   = 8;
  localparam int MAX_DW  = 64;

  typedef enum logic [3:0] {
    OP_HALT = 4'h0,
    OP_MOV  = 4'h1,
    OP_LDR  = 4'h2,
    OP_ADD  = 4'h3,
    OP_ADC  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_SHL  = 4'h9,
    OP_SHR  = 4'hA,
    OP_LD   = 4'hB,
    OP_ST   = 4'hC,
    OP_BNZ  = 4'hD,
    OP_JMP  = 4'hE,
    OP_CLC  = 4'hF
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // result is zero-extended from DW so one type serves every width
  typedef struct packed {
    logic [MAX_DW-1:0] result;
    logic              carry;
  } alu_res_t;

endpackage

// File: rtl/acc_core_seq_if.sv
// acc_core_seq_if: run handshake plus instruction/data memory bus
// master is the core side, slave the host/memory side
interface acc_core_seq_if
  import acc_core_pkg::*;
#(
  parameter int DW       = 8,
  parameter int PC_WIDTH = 12,
  parameter int CW       = 16
) ();

  logic                req;
  logic                done;
  logic                timeout;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [INSTR_W-1:0]  imem_data;
  logic [DW-1:0]       dmem_addr;
  logic [DW-1:0]       dmem_wdata;
  logic                dmem_we;
  logic [DW-1:0]       dmem_rdata;
  logic [CW-1:0]       instr_count;

  modport master (
    input  req, imem_data, dmem_rdata,
    output done, timeout, imem_addr,
    output dmem_addr, dmem_wdata, dmem_we,
    output instr_count
  );

  modport slave (
    output req, imem_data, dmem_rdata,
    input  done, timeout, imem_addr,
    input  dmem_addr, dmem_wdata, dmem_we,
    input  instr_count
  );

endinterface

// File: rtl/acc_core_seq_alu.sv
// acc_alu: combinational ALU for the accumulator core
// carry passes through unchanged for ops that do not touch it
module acc_alu
  import acc_core_pkg::*;
#(
  parameter int DW = 8
) (
  input  op_t           i_op,
  input  logic [DW-1:0] i_acc,
  input  logic [DW-1:0] i_opnd,
  input  logic          i_cin,
  output alu_res_t      o_res,
  output logic          o_wr_acc
);

  logic [DW:0]   w_sum;
  logic [DW-1:0] w_val;

  always_comb begin
    w_sum       = '0;
    w_val       = '0;
    o_res.carry = i_cin;
    o_wr_acc    = 1'b1;
    unique case (1'b1)
      (i_op == OP_LDR): w_val = i_opnd;
      (i_op == OP_ADD): begin
        w_sum       = {1'b0, i_acc} + {1'b0, i_opnd};
        w_val       = w_sum[DW-1:0];
        o_res.carry = w_sum[DW];
      end
      (i_op == OP_ADC): begin
        w_sum       = {1'b0, i_acc} + {1'b0, i_opnd}
                    + {{DW{1'b0}}, i_cin};
        w_val       = w_sum[DW-1:0];
        o_res.carry = w_sum[DW];
      end
      (i_op == OP_SUB): begin
        w_val       = i_acc - i_opnd;
        o_res.carry = (i_acc >= i_opnd);
      end
      (i_op == OP_AND): w_val = i_acc & i_opnd;
      (i_op == OP_OR):  w_val = i_acc | i_opnd;
      (i_op == OP_XOR): w_val = i_acc ^ i_opnd;
      (i_op == OP_SHL): {o_res.carry, w_val} = {i_acc, i_cin};
      (i_op == OP_SHR): {w_val, o_res.carry} = {i_cin, i_acc};
      (i_op == OP_CLC): begin
        o_res.carry = 1'b0;
        o_wr_acc    = 1'b0;
      end
      default: o_wr_acc = 1'b0;
    endcase
    o_res.result = MAX_DW'(w_val);
  end

endmodule

// File: rtl/acc_core_seq.sv
// acc_core_seq: single-cycle accumulator core with run FSM,
// flags, saturating instruction counter and watchdog
module acc_core_seq
  import acc_core_pkg::*;
#(
  parameter int DW         = 8,
  parameter int NREG       = 16,
  parameter int PC_WIDTH   = 12,
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 0
) (
  input  logic           clk,
  input  logic           reset,
  acc_core_seq_if.master bus
);

  localparam int RW = $clog2(NREG);

  state_t              r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt, w_off;
  logic [DW-1:0]       r_regs [NREG];
  logic                r_c, r_z, r_timeout;
  logic [CW-1:0]       r_cnt, w_cnt_inc;
  logic [INSTR_W-1:0]  w_instr;
  logic                w_ldi, w_halt, w_wdog;
  logic                w_taken, w_run;
  op_t                 w_op;
  logic [RW-1:0]       w_ridx;
  logic [DW-1:0]       w_opnd;
  alu_res_t            w_alu;
  logic                w_alu_wr, w_alu_z;

  assign w_instr   = bus.imem_data;
  assign w_ldi     = w_instr[INSTR_W-1];
  assign w_op      = op_t'(w_instr[7:4]);
  assign w_ridx    = w_instr[RW-1:0];
  assign w_opnd    = r_regs[w_ridx];
  assign w_run     = (r_state == S_RUN);
  assign w_halt    = !w_ldi && (w_op == OP_HALT);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
  assign w_wdog    = (MAX_CYCLES != 0)
                  && (w_cnt_inc == CW'(MAX_CYCLES));
  assign w_alu_z   = (w_alu.result == '0);

  generate
    if (PC_WIDTH <= DW) begin : g_trunc
      assign w_off = w_opnd[PC_WIDTH-1:0];
    end else begin : g_sext
      assign w_off = {{(PC_WIDTH-DW){w_opnd[DW-1]}}, w_opnd};
    end
  endgenerate

  assign w_taken  = !w_ldi && ((w_op == OP_JMP)
                 || ((w_op == OP_BNZ) && !r_z));
  assign w_pc_nxt = w_taken ? r_pc + w_off
                            : r_pc + PC_WIDTH'(1);

  acc_alu #(.DW(DW)) u_alu (
    .i_op     (w_op),
    .i_acc    (r_regs[0]),
    .i_opnd   (w_opnd),
    .i_cin    (r_c),
    .o_res    (w_alu),
    .o_wr_acc (w_alu_wr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (bus.req) w_state_nxt = S_RUN;
      S_RUN:  if (w_halt || w_wdog) w_state_nxt = S_DONE;
      S_DONE: if (!bus.req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= '0;
      r_cnt     <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_timeout <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_run) begin
      r_pc      <= w_pc_nxt;
      r_cnt     <= w_cnt_inc;
      // HALT in the watchdog's final cycle is a clean finish
      r_timeout <= w_wdog && !w_halt;
      if (w_ldi) begin
        r_regs[0] <= DW'(w_instr[IMM_W-1:0]);
        r_z       <= (w_instr[IMM_W-1:0] == '0);
      end else if (w_op == OP_LD) begin
        r_regs[0] <= bus.dmem_rdata;
        r_z       <= (bus.dmem_rdata == '0);
      end else begin
        r_c <= w_alu.carry;
        if (w_alu_wr) begin
          r_regs[0] <= w_alu.result[DW-1:0];
          r_z       <= w_alu_z;
        end
        if (w_op == OP_MOV) r_regs[w_ridx] <= r_regs[0];
      end
    end else if ((r_state == S_IDLE) && bus.req) begin
      r_pc      <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end
  end

  assign bus.done        = (r_state == S_DONE);
  assign bus.timeout     = r_timeout;
  assign bus.imem_addr   = r_pc;
  assign bus.dmem_addr   = w_opnd;
  assign bus.dmem_wdata  = r_regs[0];
  assign bus.dmem_we     = w_run && !w_ldi && (w_op == OP_ST);
  assign bus.instr_count = r_cnt;

endmodule

// File: tb/tb_acc_core_seq.sv
// tb_acc_core_seq: directed programs on three core builds
// u0 default, u1 watchdog of 4, u2 16-bit data with 4-bit PC
module tb_acc_core_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  acc_core_seq_if #(.DW(8),  .PC_WIDTH(12), .CW(16)) b0 ();
  acc_core_seq_if #(.DW(8),  .PC_WIDTH(12), .CW(16)) b1 ();
  acc_core_seq_if #(.DW(16), .PC_WIDTH(4),  .CW(16)) b2 ();

  logic [8:0] rom0 [4096];
  logic [8:0] rom1 [4096];
  logic [8:0] rom2 [16];
  logic [7:0] mem0 [256];

  assign b0.imem_data  = rom0[b0.imem_addr];
  assign b0.dmem_rdata = mem0[b0.dmem_addr];
  assign b1.imem_data  = rom1[b1.imem_addr];
  assign b1.dmem_rdata = '0;
  assign b2.imem_data  = rom2[b2.imem_addr];
  assign b2.dmem_rdata = '0;

  always @(posedge clk)
    if (b0.dmem_we) mem0[b0.dmem_addr] <= b0.dmem_wdata;

  acc_core_seq #(.DW(8), .NREG(16), .PC_WIDTH(12), .CW(16),
                 .MAX_CYCLES(0)) u0 (
    .clk(clk), .reset(rst_n), .bus(b0));
  acc_core_seq #(.DW(8), .NREG(16), .PC_WIDTH(12), .CW(16),
                 .MAX_CYCLES(4)) u1 (
    .clk(clk), .reset(rst_n), .bus(b1));
  acc_core_seq #(.DW(16), .NREG(16), .PC_WIDTH(4), .CW(16),
                 .MAX_CYCLES(0)) u2 (
    .clk(clk), .reset(rst_n), .bus(b2));

  task automatic test_reset;
    rst_n = 1'b0;
    b0.req = 1'b0; b1.req = 1'b0; b2.req = 1'b0;
    #12;
    total++;
    if (b0.done !== 1'b0) begin
      bad++; $display("FAIL rst_done got=%b exp=0", b0.done);
    end
    total++;
    if (b0.timeout !== 1'b0) begin
      bad++; $display("FAIL rst_timeout got=%b exp=0", b0.timeout);
    end
    total++;
    if (b0.imem_addr !== 12'h000) begin
      bad++; $display("FAIL rst_pc got=%0h exp=0", b0.imem_addr);
    end
    total++;
    if (b0.instr_count !== 16'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d exp=0", b0.instr_count);
    end
    total++;
    if (b0.dmem_we !== 1'b0) begin
      bad++; $display("FAIL rst_we got=%b exp=0", b0.dmem_we);
    end
    total++;
    if (b2.dmem_wdata !== 16'h0000) begin
      bad++; $display("FAIL rst_acc got=%0h exp=0", b2.dmem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith;
    int n; bit seen; logic [11:0] first_pc;
    n = 0; seen = 0; first_pc = 12'hFFF;
    for (int i = 0; i < 4096; i++) rom0[i] = 9'h000;
    rom0[0] = 9'h1F0; rom0[1] = 9'h011; rom0[2] = 9'h120;
    rom0[3] = 9'h031; rom0[4] = 9'h000;
    @(negedge clk); b0.req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if (n == 1) first_pc = b0.imem_addr;
      if (b0.done) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL ar_wait got=none exp=done"); end
    total++;
    if (n != 6) begin bad++; $display("FAIL ar_latency got=%0d exp=6", n); end
    total++;
    if (first_pc !== 12'h000) begin
      bad++; $display("FAIL ar_startpc got=%0h exp=0", first_pc);
    end
    total++;
    if (b0.dmem_wdata !== 8'h10) begin
      bad++; $display("FAIL ar_acc got=%0h exp=10", b0.dmem_wdata);
    end
    total++;
    if (u0.r_c !== 1'b1 || u0.r_z !== 1'b0) begin
      bad++; $display("FAIL ar_flags got=c%b z%b exp=c1 z0", u0.r_c, u0.r_z);
    end
    total++;
    if (b0.instr_count !== 16'd5) begin
      bad++; $display("FAIL ar_cnt got=%0d exp=5", b0.instr_count);
    end
    total++;
    if (b0.timeout !== 1'b0) begin
      bad++; $display("FAIL ar_timeout got=%b exp=0", b0.timeout);
    end
    b0.req = 1'b0;
    @(negedge clk);
    total++;
    if (b0.done !== 1'b0) begin
      bad++; $display("FAIL ar_idle got=%b exp=0", b0.done);
    end
  endtask

  task automatic test_memory;
    int n, we_n; bit seen; logic [7:0] wa, wd;
    n = 0; we_n = 0; seen = 0; wa = '0; wd = '0;
    for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
    for (int i = 0; i < 4096; i++) rom0[i] = 9'h000;
    rom0[0] = 9'h105; rom0[1] = 9'h014; rom0[2] = 9'h1A5;
    rom0[3] = 9'h0C4; rom0[4] = 9'h100; rom0[5] = 9'h0B4;
    rom0[6] = 9'h000; rom0[7] = 9'h0C4;
    @(negedge clk); b0.req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if (b0.done) begin seen = 1; break; end
      if (b0.dmem_we) begin
        we_n++; wa = b0.dmem_addr; wd = b0.dmem_wdata;
      end
    end
    total++;
    if (!seen || n != 8) begin
      bad++; $display("FAIL mem_wait got=%0d exp=8", n);
    end
    total++;
    if (we_n != 1) begin bad++; $display("FAIL mem_we_n got=%0d exp=1", we_n); end
    total++;
    if (wa !== 8'h05 || wd !== 8'hA5) begin
      bad++; $display("FAIL mem_st got=%0h/%0h exp=5/a5", wa, wd);
    end
    total++;
    if (b0.dmem_wdata !== 8'hA5) begin
      bad++; $display("FAIL mem_ld got=%0h exp=a5", b0.dmem_wdata);
    end
    total++;
    if (b0.instr_count !== 16'd7) begin
      bad++; $display("FAIL mem_cnt got=%0d exp=7", b0.instr_count);
    end
    total++;
    if (b0.dmem_we !== 1'b0) begin
      bad++; $display("FAIL mem_we_done got=%b exp=0", b0.dmem_we);
    end
    b0.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_branch;
    int n, bnz_n; bit seen, saw10;
    n = 0; bnz_n = 0; seen = 0; saw10 = 0;
    for (int i = 0; i < 4096; i++) rom0[i] = 9'h000;
    rom0[0] = 9'h103; rom0[1] = 9'h011; rom0[2] = 9'h101;
    rom0[3] = 9'h012; rom0[4] = 9'h1FD; rom0[5] = 9'h013;
    rom0[6] = 9'h021; rom0[7] = 9'h052; rom0[8] = 9'h011;
    rom0[9] = 9'h0D3; rom0[10] = 9'h000;
    @(negedge clk); b0.req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); n++;
      if (b0.done) begin seen = 1; break; end
      if (b0.imem_addr == 12'd9) bnz_n++;
      if (b0.imem_addr == 12'd10) saw10 = 1;
    end
    total++;
    if (!seen || n != 20) begin
      bad++; $display("FAIL br_wait got=%0d exp=20", n);
    end
    total++;
    if (bnz_n != 3) begin bad++; $display("FAIL br_iters got=%0d exp=3", bnz_n); end
    total++;
    if (!saw10) begin bad++; $display("FAIL br_halt_pc got=none exp=10"); end
    total++;
    if (u0.r_regs[1] !== 8'h00 || u0.r_z !== 1'b1) begin
      bad++; $display("FAIL br_r1z got=%0h z%b exp=0 z1", u0.r_regs[1], u0.r_z);
    end
    total++;
    if (u0.r_c !== 1'b1) begin bad++; $display("FAIL br_c got=%b exp=1", u0.r_c); end
    total++;
    if (b0.instr_count !== 16'd19) begin
      bad++; $display("FAIL br_cnt got=%0d exp=19", b0.instr_count);
    end
    b0.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_watchdog;
    int n; bit seen;
    n = 0; seen = 0;
    for (int i = 0; i < 4096; i++) rom1[i] = 9'h000;
    rom1[0] = 9'h0E0;
    @(negedge clk); b1.req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if (b1.done) begin seen = 1; break; end
    end
    total++;
    if (!seen || n != 5) begin
      bad++; $display("FAIL wd_wait got=%0d exp=5", n);
    end
    total++;
    if (b1.timeout !== 1'b1) begin
      bad++; $display("FAIL wd_timeout got=%b exp=1", b1.timeout);
    end
    total++;
    if (b1.instr_count !== 16'd4 || b1.imem_addr !== 12'h000) begin
      bad++; $display("FAIL wd_cnt got=%0d pc%0h exp=4 pc0", b1.instr_count, b1.imem_addr);
    end
    repeat (3) @(negedge clk);
    total++;
    if (b1.done !== 1'b1 || b1.instr_count !== 16'd4) begin
      bad++; $display("FAIL wd_hold got=%b/%0d exp=1/4", b1.done, b1.instr_count);
    end
    b1.req = 1'b0;
    @(negedge clk);
    total++;
    if (b1.done !== 1'b0) begin bad++; $display("FAIL wd_idle got=%b exp=0", b1.done); end
  endtask

  task automatic test_halt_wins;
    int n; bit seen;
    n = 0; seen = 0;
    for (int i = 0; i < 4096; i++) rom1[i] = 9'h000;
    rom1[0] = 9'h101; rom1[1] = 9'h102; rom1[2] = 9'h103;
    rom1[3] = 9'h000;
    @(negedge clk); b1.req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if (b1.done) begin seen = 1; break; end
    end
    total++;
    if (!seen || n != 5) begin
      bad++; $display("FAIL hw_wait got=%0d exp=5", n);
    end
    total++;
    if (b1.timeout !== 1'b0 || b1.instr_count !== 16'd4) begin
      bad++; $display("FAIL hw_timeout got=%b/%0d exp=0/4", b1.timeout, b1.instr_count);
    end
    total++;
    if (b1.dmem_wdata !== 8'h03) begin
      bad++; $display("FAIL hw_acc got=%0h exp=3", b1.dmem_wdata);
    end
    b1.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int n, wraps; bit seen; logic [15:0] acc5; logic [3:0] prev;
    n = 0; seen = 0; acc5 = '0;
    for (int i = 0; i < 16; i++) rom2[i] = 9'h000;
    rom2[0] = 9'h102; rom2[1] = 9'h016; rom2[2] = 9'h101;
    rom2[3] = 9'h0A0; rom2[4] = 9'h1FF; rom2[5] = 9'h090;
    rom2[6] = 9'h000;
    @(negedge clk); b2.req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if (b2.done) begin seen = 1; break; end
      if (b2.imem_addr == 4'd5) acc5 = b2.dmem_wdata;
    end
    total++;
    if (!seen || n != 8) begin bad++; $display("FAIL wr_wait1 got=%0d exp=8", n); end
    total++;
    if (acc5 !== 16'h00FF) begin bad++; $display("FAIL wr_ldi got=%0h exp=ff", acc5); end
    total++;
    if (b2.dmem_wdata !== 16'h01FF || u2.r_c !== 1'b0) begin
      bad++; $display("FAIL wr_shl got=%0h c%b exp=1ff c0", b2.dmem_wdata, u2.r_c);
    end
    total++;
    if (b2.instr_count !== 16'd7) begin
      bad++; $display("FAIL wr_cnt1 got=%0d exp=7", b2.instr_count);
    end
    b2.req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) rom2[i] = 9'h010;
    rom2[0] = 9'h0D6; rom2[1] = 9'h000; rom2[2] = 9'h100;
    n = 0; seen = 0; wraps = 0; prev = 4'd0;
    @(negedge clk); b2.req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); n++;
      if (b2.done) begin seen = 1; break; end
      if (prev == 4'd15 && b2.imem_addr == 4'd0) wraps++;
      prev = b2.imem_addr;
    end
    total++;
    if (!seen || n != 18) begin bad++; $display("FAIL wr_wait2 got=%0d exp=18", n); end
    total++;
    if (wraps != 1) begin bad++; $display("FAIL wr_wrap got=%0d exp=1", wraps); end
    total++;
    if (b2.instr_count !== 16'd17) begin
      bad++; $display("FAIL wr_cnt2 got=%0d exp=17", b2.instr_count);
    end
    b2.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    for (int i = 0; i < 4096; i++) rom0[i] = 9'h000;
    rom0[0] = 9'h100; rom0[1] = 9'h0E0;
    @(negedge clk); b0.req = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (b0.done !== 1'b0 || b0.imem_addr !== 12'd1) begin
      bad++; $display("FAIL rm_loop got=%b pc%0h exp=0 pc1", b0.done, b0.imem_addr);
    end
    #2 rst_n = 1'b0; b0.req = 1'b0;
    #1;
    total++;
    if (b0.done !== 1'b0 || b0.imem_addr !== 12'h000) begin
      bad++; $display("FAIL rm_async got=%b pc%0h exp=0 pc0", b0.done, b0.imem_addr);
    end
    total++;
    if (b0.instr_count !== 16'd0) begin
      bad++; $display("FAIL rm_cnt got=%0d exp=0", b0.instr_count);
    end
    total++;
    if (u0.r_regs[4] !== 8'h00 || u0.r_regs[2] !== 8'h00) begin
      bad++; $display("FAIL rm_regs got=%0h/%0h exp=0/0", u0.r_regs[4], u0.r_regs[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_arith();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rom0[i] = 9'h000; rom1[i] = 9'h000;
    end
    for (int i = 0; i < 16; i++) rom2[i] = 9'h000;
    for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
    test_reset();
    test_arith();
    test_memory();
    test_branch();
    test_watchdog();
    test_halt_wins();
    test_wrap();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
